// File: rtl/btn_debounce.sv
// btn_debounce
// Conditions one asynchronous push-button pin for the system clock domain.
// The pin is optionally inverted so that 1 always means "pressed". It is then
// synchronised and filtered by a four-state debounce FSM. The block produces:
//   btn_o     - clean, debounced level
//   press_o   - one-cycle pulse on an accepted press
//   release_o - one-cycle pulse on an accepted release
//   long_o    - one-cycle pulse after the button has been held long enough
// All outputs are registered. The three pulses come from distinct FSM states,
// so they can never be high in the same cycle.

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int ACTIVE_HIGH     = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic btn_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    // Counter widths. LONG_CYCLES = 0 disables the long-press feature, but the
    // long counter still needs at least one bit to stay a legal vector.
    localparam int DB_W   = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int LONG_W = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);
    // Value the long counter holds on the edge where it steps onto LONG_MAX.
    localparam logic [LONG_W-1:0] LONG_PRE = LONG_W'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } state_t;

    state_t              state;
    logic [DB_W-1:0]     db_cnt;
    logic [LONG_W-1:0]   long_cnt;
    logic                pin_lvl;
    logic                sync_p0;
    logic                sync_p1;

    // Normalise polarity before the synchroniser so that 1 always means pressed.
    assign pin_lvl = (ACTIVE_HIGH != 0) ? btn_i : ~btn_i;

    // Two-flop synchroniser. Both flops reset to the released level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= pin_lvl;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce FSM, stability and long-press counters, and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= RELEASED;
            db_cnt    <= '0;
            long_cnt  <= '0;
            btn_o     <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
        end else begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            case (state)
                RELEASED: begin
                    if (sync_p1) begin
                        state  <= PRESS_PEND;
                        db_cnt <= DB_W'(1);
                    end
                end

                PRESS_PEND: begin
                    if (!sync_p1) begin
                        // Bounce: drop the candidate completely, no partial credit.
                        state  <= RELEASED;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_MAX) begin
                        state    <= PRESSED;
                        btn_o    <= 1'b1;
                        press_o  <= 1'b1;
                        long_cnt <= '0;
                        db_cnt   <= '0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end

                PRESSED: begin
                    // Hold time only accrues here; it saturates at LONG_MAX, so
                    // long_o fires exactly once per press.
                    if ((LONG_CYCLES != 0) && (long_cnt != LONG_MAX)) begin
                        long_cnt <= long_cnt + 1'b1;
                        if (long_cnt == LONG_PRE) begin
                            long_o <= 1'b1;
                        end
                    end
                    if (!sync_p1) begin
                        state  <= RELEASE_PEND;
                        db_cnt <= DB_W'(1);
                    end
                end

                RELEASE_PEND: begin
                    // btn_o stays high and the long counter is frozen while a
                    // release is being qualified.
                    if (sync_p1) begin
                        state  <= PRESSED;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_MAX) begin
                        state     <= RELEASED;
                        btn_o     <= 1'b0;
                        release_o <= 1'b1;
                        db_cnt    <= '0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= RELEASED;
                    db_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench for btn_debounce.
// Instance A: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_HIGH=1.
// Instance B: DEBOUNCE_CYCLES=1, LONG_CYCLES=0, ACTIVE_HIGH=0.
// The reference model works on sampled levels: a new level is accepted after
// DEBOUNCE_CYCLES+1 consecutive differing samples. Long-press hold time
// accrues only while the button is settled in the pressed level.

module tb_btn_debounce;

    localparam int DB_A = 4;
    localparam int LG_A = 20;
    localparam int AH_A = 1;
    localparam int DB_B = 1;
    localparam int LG_B = 0;
    localparam int AH_B = 0;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic btn_a, btn_b;
    logic a_btn, a_press, a_rel, a_long;
    logic b_btn, b_press, b_rel, b_long;

    int checks = 0;
    int errors = 0;

    // Model state, indexed by instance (0 = A, 1 = B)
    int   db_p[2] = '{DB_A, DB_B};
    int   lg_p[2] = '{LG_A, LG_B};
    int   ah_p[2] = '{AH_A, AH_B};
    bit   m_p0[2], m_p1[2], m_lvl[2], m_fired[2];
    int   m_run[2], m_hold[2];
    logic [3:0] exp_v[2];   // {btn, press, release, long}

    btn_debounce #(.DEBOUNCE_CYCLES(DB_A), .LONG_CYCLES(LG_A), .ACTIVE_HIGH(AH_A)) dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_a),
        .btn_o(a_btn), .press_o(a_press), .release_o(a_rel), .long_o(a_long)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DB_B), .LONG_CYCLES(LG_B), .ACTIVE_HIGH(AH_B)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_b),
        .btn_o(b_btn), .press_o(b_press), .release_o(b_rel), .long_o(b_long)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [3:0] obs_a();
        return {a_btn, a_press, a_rel, a_long};
    endfunction

    function automatic logic [3:0] obs_b();
        return {b_btn, b_press, b_rel, b_long};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_p0[k] = 0; m_p1[k] = 0; m_lvl[k] = 0; m_fired[k] = 0;
            m_run[k] = 0; m_hold[k] = 0; exp_v[k] = 4'b0000;
        end
    endtask

    task automatic model_step(input int k, input bit pin);
        bit s, prev_lvl, settled, pr, rl, lg;
        s = m_p1[k];
        m_p1[k] = m_p0[k];
        m_p0[k] = (ah_p[k] != 0) ? pin : !pin;
        prev_lvl = m_lvl[k];
        settled = (m_run[k] == 0);
        pr = 0; rl = 0; lg = 0;
        if (s != m_lvl[k]) begin
            m_run[k]++;
            if (m_run[k] == db_p[k] + 1) begin
                m_lvl[k] = s;
                m_run[k] = 0;
                if (s) begin
                    pr = 1; m_hold[k] = 0; m_fired[k] = 0;
                end else begin
                    rl = 1;
                end
            end
        end else begin
            m_run[k] = 0;
        end
        if (prev_lvl && settled) begin
            m_hold[k]++;
            if (lg_p[k] != 0 && !m_fired[k] && m_hold[k] == lg_p[k]) begin
                lg = 1; m_fired[k] = 1;
            end
        end
        exp_v[k] = {m_lvl[k], pr, rl, lg};
    endtask

    // Drive both pins, advance one clock, update the model, return at negedge.
    task automatic tick(input bit a, input bit b);
        btn_a = a;
        btn_b = b;
        @(posedge clk_i);
        if (rst_ni) begin
            model_step(0, a);
            model_step(1, b);
        end else begin
            model_reset();
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        btn_a = 1'b0;
        btn_b = 1'b1;
        model_reset();
        repeat (3) @(negedge clk_i);
        checks++;
        if (obs_a() !== 4'b0000) begin
            errors++;
            $display("FAIL reset_a: got %b expected 0000", obs_a());
        end
        checks++;
        if (obs_b() !== 4'b0000) begin
            errors++;
            $display("FAIL reset_b: got %b expected 0000", obs_b());
        end
        rst_ni = 1'b1;
        for (int j = 0; j < 4; j++) tick(0, 1);
    endtask

    task automatic test_clean_press();
        int n = 0, at = -1;
        for (int j = 0; j < 10; j++) begin
            tick(1, 1);
            checks++;
            if (obs_a() !== exp_v[0]) begin
                errors++;
                $display("FAIL clean_press cyc %0d: got %b expected %b", j, obs_a(), exp_v[0]);
            end
            if (a_press) begin n++; at = j; end
        end
        checks++;
        if (n !== 1 || at !== 2 + DB_A) begin
            errors++;
            $display("FAIL clean_press_timing: got %0d pulses last at %0d, expected 1 at %0d", n, at, 2 + DB_A);
        end
        checks++;
        if (a_btn !== 1'b1) begin
            errors++;
            $display("FAIL clean_press_level: got %b expected 1", a_btn);
        end
    endtask

    task automatic test_release_glitch();
        bit pat[8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        int bad = 0, at = -1, n = 0;
        for (int j = 0; j < 8; j++) begin
            tick(pat[j], 1);
            checks++;
            if (obs_a() !== exp_v[0]) begin
                errors++;
                $display("FAIL glitch cyc %0d: got %b expected %b", j, obs_a(), exp_v[0]);
            end
            if (a_rel || a_press || !a_btn) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL glitch_filtered: got %0d disturbed cycles, expected 0", bad);
        end
        for (int j = 0; j < 10; j++) begin
            tick(0, 1);
            checks++;
            if (obs_a() !== exp_v[0]) begin
                errors++;
                $display("FAIL clean_release cyc %0d: got %b expected %b", j, obs_a(), exp_v[0]);
            end
            if (a_rel) begin n++; at = j; end
        end
        checks++;
        if (n !== 1 || at !== 2 + DB_A) begin
            errors++;
            $display("FAIL release_timing: got %0d pulses last at %0d, expected 1 at %0d", n, at, 2 + DB_A);
        end
    endtask

    task automatic test_bouncy_press();
        bit pat[5] = '{1, 0, 1, 1, 0};
        int early = 0, n = 0, at = -1;
        for (int j = 0; j < 5; j++) begin
            tick(pat[j], 1);
            checks++;
            if (obs_a() !== exp_v[0]) begin
                errors++;
                $display("FAIL bounce cyc %0d: got %b expected %b", j, obs_a(), exp_v[0]);
            end
            if (a_press || a_btn) early++;
        end
        for (int j = 0; j < 10; j++) begin
            tick(1, 1);
            checks++;
            if (obs_a() !== exp_v[0]) begin
                errors++;
                $display("FAIL bounce_hold cyc %0d: got %b expected %b", j, obs_a(), exp_v[0]);
            end
            if (a_press) begin n++; at = j; end
            if (j < 2 + DB_A && (a_press || a_btn)) early++;
        end
        checks++;
        if (early !== 0 || n !== 1 || at !== 2 + DB_A) begin
            errors++;
            $display("FAIL bounce_press: got early=%0d pulses=%0d at %0d, expected 0/1/%0d", early, n, at, 2 + DB_A);
        end
        for (int j = 0; j < 10; j++) tick(0, 1);
        checks++;
        if (obs_a() !== 4'b0000) begin
            errors++;
            $display("FAIL bounce_release: got %b expected 0000", obs_a());
        end
    endtask

    task automatic test_long_press();
        int p_at = -1, l_at = -1, ln = 0, rn = 0, late_long = 0;
        for (int j = 0; j < 7 + 40; j++) begin
            tick(1, 1);
            checks++;
            if (obs_a() !== exp_v[0]) begin
                errors++;
                $display("FAIL long_hold cyc %0d: got %b expected %b", j, obs_a(), exp_v[0]);
            end
            if (a_press) p_at = j;
            if (a_long) begin ln++; l_at = j; end
        end
        checks++;
        if (ln !== 1 || l_at - p_at !== LG_A) begin
            errors++;
            $display("FAIL long_timing: got %0d pulses, delay %0d, expected 1 pulse, delay %0d", ln, l_at - p_at, LG_A);
        end
        for (int j = 0; j < 10; j++) begin
            tick(0, 1);
            if (a_rel) rn++;
            if (a_long) late_long++;
        end
        checks++;
        if (rn !== 1 || late_long !== 0) begin
            errors++;
            $display("FAIL long_release: got %0d releases, %0d late long, expected 1 and 0", rn, late_long);
        end
    endtask

    task automatic test_short_press();
        int pn = 0, rn = 0, ln = 0, r_at = -1;
        for (int j = 0; j < 10; j++) begin
            tick(1, 1);
            if (a_press) pn++;
            if (a_long) ln++;
        end
        for (int j = 0; j < 10; j++) begin
            tick(0, 1);
            checks++;
            if (obs_a() !== exp_v[0]) begin
                errors++;
                $display("FAIL short_release cyc %0d: got %b expected %b", j, obs_a(), exp_v[0]);
            end
            if (a_rel) begin rn++; r_at = j; end
            if (a_long) ln++;
        end
        checks++;
        if (pn !== 1 || rn !== 1 || ln !== 0 || r_at !== 2 + DB_A) begin
            errors++;
            $display("FAIL short_press: got press=%0d rel=%0d long=%0d rel_at=%0d, expected 1/1/0/%0d",
                     pn, rn, ln, r_at, 2 + DB_A);
        end
    endtask

    task automatic test_min_debounce();
        int pn = 0, p_at = -1, rn = 0, r_at = -1, ln = 0;
        // Instance B is active-low: pin 0 is pressed.
        for (int j = 0; j < 12; j++) begin
            tick(0, 0);
            checks++;
            if (obs_b() !== exp_v[1]) begin
                errors++;
                $display("FAIL min_press cyc %0d: got %b expected %b", j, obs_b(), exp_v[1]);
            end
            if (b_press) begin pn++; p_at = j; end
            if (b_long) ln++;
        end
        for (int j = 0; j < 30; j++) begin
            tick(0, 0);
            if (b_long || b_press) ln++;
        end
        for (int j = 0; j < 8; j++) begin
            tick(0, 1);
            checks++;
            if (obs_b() !== exp_v[1]) begin
                errors++;
                $display("FAIL min_release cyc %0d: got %b expected %b", j, obs_b(), exp_v[1]);
            end
            if (b_rel) begin rn++; r_at = j; end
        end
        checks++;
        if (pn !== 1 || p_at !== 2 + DB_B || rn !== 1 || r_at !== 2 + DB_B || ln !== 0) begin
            errors++;
            $display("FAIL min_debounce: got press %0d@%0d rel %0d@%0d extra=%0d, expected 1@%0d 1@%0d 0",
                     pn, p_at, rn, r_at, ln, 2 + DB_B, 2 + DB_B);
        end
    endtask

    task automatic test_reset_mid_press();
        int rn = 0, pn = 0, p_at = -1;
        for (int j = 0; j < 10; j++) tick(1, 0);
        checks++;
        if (a_btn !== 1'b1 || b_btn !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_setup: got a=%b b=%b expected 1 1", a_btn, b_btn);
        end
        rst_ni = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({obs_a(), obs_b()} !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_async: got %b expected 00000000", {obs_a(), obs_b()});
        end
        @(negedge clk_i);
        for (int j = 0; j < 3; j++) begin
            tick(1, 0);
            if (a_rel || b_rel || a_btn || b_btn) rn++;
        end
        rst_ni = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick(1, 0);
            checks++;
            if (obs_a() !== exp_v[0]) begin
                errors++;
                $display("FAIL mid_reset_repress cyc %0d: got %b expected %b", j, obs_a(), exp_v[0]);
            end
            if (a_press) begin pn++; p_at = j; end
            if (a_rel) rn++;
        end
        checks++;
        if (rn !== 0 || pn !== 1 || p_at !== 2 + DB_A) begin
            errors++;
            $display("FAIL mid_reset_timing: got rel=%0d press %0d@%0d, expected 0 and 1@%0d", rn, pn, p_at, 2 + DB_A);
        end
        for (int j = 0; j < 10; j++) tick(0, 1);
    endtask

    task automatic test_random();
        bit la = 0, lb = 1;
        int ra = 0, rb = 0;
        int bad_a = 0, bad_b = 0, excl = 0;
        for (int j = 0; j < 3000; j++) begin
            if (ra == 0) begin la = $urandom_range(0, 1); ra = $urandom_range(1, 40); end
            if (rb == 0) begin lb = $urandom_range(0, 1); rb = $urandom_range(1, 6); end
            ra--; rb--;
            tick(la, lb);
            checks++;
            if (obs_a() !== exp_v[0]) begin
                errors++;
                bad_a++;
                if (bad_a < 10)
                    $display("FAIL random_a cyc %0d: got %b expected %b", j, obs_a(), exp_v[0]);
            end
            checks++;
            if (obs_b() !== exp_v[1]) begin
                errors++;
                bad_b++;
                if (bad_b < 10)
                    $display("FAIL random_b cyc %0d: got %b expected %b", j, obs_b(), exp_v[1]);
            end
            if (int'(a_press) + int'(a_rel) + int'(a_long) > 1) excl++;
        end
        checks++;
        if (excl !== 0) begin
            errors++;
            $display("FAIL pulse_exclusive: got %0d overlapping cycles, expected 0", excl);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release_glitch();
        test_bouncy_press();
        test_long_press();
        test_short_press();
        test_min_debounce();
        test_reset_mid_press();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
